noc_channel_arbiter: RTL

Clocked round-robin arbiter that shares one two-phase (transition-signalling) pipeline channel among NUM_CH requesting channels. Each requester presents a req/data/ack bundle with the same two-phase protocol as the pipeline stages. The arbiter selects one pending requester and forwards its word on the shared output channel. It then returns the downstream acknowledge to that requester only. The block sits at the injection point of a router output port, ahead of the first pipeline stage of the shared link.

---
 rtl/noc_channel_arbiter_if.sv | 35 +++
 rtl/noc_channel_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/noc_channel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_channel_arbiter_if
// Brief    : Requester-side and shared-channel two-phase bundle for the
//            NoC channel arbiter.
// Revision : 1.0
// ============================================================================
interface noc_channel_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int WORD_WIDTH = 32
);
  localparam int c_idx_w = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            req_in;
  logic [NUM_CH*WORD_WIDTH-1:0] data_in;
  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            ack_in;
  logic                         req_out;
  logic [WORD_WIDTH-1:0]        data_out;
  logic                         ack_out;
  logic [c_idx_w-1:0]           grant_id;
  logic                         busy;

  // master drives requests and the downstream acknowledge; slave is the arbiter
  modport master (
    output req_in, data_in, ch_enable, ack_out,
    input  ack_in, req_out, data_out, grant_id, busy
  );

  modport slave (
    input  req_in, data_in, ch_enable, ack_out,
    output ack_in, req_out, data_out, grant_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/noc_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_channel_arbiter
// Brief    : Round-robin arbiter sharing one two-phase pipeline channel among
//            NUM_CH two-phase requesters.
// Revision : 1.0
// ============================================================================
module noc_channel_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int WORD_WIDTH = 32
) (
  input wire                   clk,
  input wire                   reset,
  noc_channel_arbiter_if.slave bus
);
  localparam int                 c_idx_w    = $clog2(NUM_CH);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CH - 1);
  localparam logic [c_idx_w-1:0] c_one_idx  = c_idx_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_CH-1:0]     r_ack_in;
  logic                  r_req_out;
  logic [WORD_WIDTH-1:0] r_data_out;
  logic [c_idx_w-1:0]    r_grant_id;
  logic [c_idx_w-1:0]    r_rr_ptr;
  logic                  r_busy;

  logic [NUM_CH-1:0]     w_eligible;
  logic [WORD_WIDTH-1:0] w_words [NUM_CH];
  logic [c_idx_w-1:0]    w_cand;
  logic [c_idx_w-1:0]    w_sel;
  logic                  w_found;
  logic                  w_out_free;
  logic                  w_grant;
  logic                  w_release;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign w_words[gi] = bus.data_in[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  // Pending is judged against the registered ack_in, so a just-released
  // channel cannot be re-granted on the edge it is acknowledged.
  assign w_eligible = (bus.req_in ^ r_ack_in) & bus.ch_enable;
  assign w_out_free = (bus.ack_out == r_req_out);

  // First eligible index starting just after the last winner, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = r_rr_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = (w_cand == c_last_idx) ? '0 : w_cand + c_one_idx;
      if (!w_found && w_eligible[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found && w_out_free) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_out_free) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_in   <= '0;
      r_req_out  <= 1'b0;
      r_data_out <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= c_last_idx;
      r_busy     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_data_out <= w_words[w_sel];
        r_req_out  <= ~r_req_out;
        r_grant_id <= w_sel;
        r_busy     <= 1'b1;
      end
      if (w_release) begin
        r_ack_in[r_grant_id] <= ~r_ack_in[r_grant_id];
        r_rr_ptr             <= r_grant_id;
        r_busy               <= 1'b0;
      end
    end
  end

  assign bus.ack_in   = r_ack_in;
  assign bus.req_out  = r_req_out;
  assign bus.data_out = r_data_out;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire
